// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and helpers for the demux stream router
package demux_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    localparam int DROP_CNT_W = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/demux_hold_reg.sv
// rtl/demux_hold_reg.sv - single-entry holding register with valid/ready handshake
module demux_hold_reg #(
    parameter int N_CH = 4,
    parameter int DW   = 1,
    parameter int SW   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_i,
    input  logic            in_valid_i,
    input  logic            in_drop_i,
    input  logic [SW-1:0]   in_ch_i,
    input  logic [DW-1:0]   in_data_i,
    input  logic            in_last_i,
    input  logic [N_CH-1:0] out_ready_i,
    output logic            in_ready_o,
    output logic            accept_o,
    output logic            buf_valid_o,
    output logic [SW-1:0]   buf_ch_o,
    output logic [DW-1:0]   buf_data_o,
    output logic            buf_last_o
);

    logic          buf_valid_q, buf_valid_d;
    logic [SW-1:0] buf_ch_q, buf_ch_d;
    logic [DW-1:0] buf_data_q, buf_data_d;
    logic          buf_last_q, buf_last_d;
    logic          sel_ready;
    logic          drain;
    logic          load;

    always_comb begin
        sel_ready = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (buf_ch_q == k[SW-1:0]) begin
                sel_ready = out_ready_i[k];
            end
        end
    end

    // Gating with rst_n keeps in_ready low while reset is held, yet allows
    // acceptance on the very first edge after release.
    assign drain      = buf_valid_q && sel_ready;
    assign in_ready_o = rst_n && en_i && (!buf_valid_q || sel_ready);
    assign accept_o   = in_valid_i && in_ready_o;
    assign load       = accept_o && !in_drop_i;

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_ch_d    = buf_ch_q;
        buf_data_d  = buf_data_q;
        buf_last_d  = buf_last_q;
        if (load) begin
            buf_valid_d = 1'b1;
            buf_ch_d    = in_ch_i;
            buf_data_d  = in_data_i;
            buf_last_d  = in_last_i;
        end else if (drain) begin
            buf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid_q <= 1'b0;
            buf_ch_q    <= '0;
            buf_data_q  <= '0;
            buf_last_q  <= 1'b0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_ch_q    <= buf_ch_d;
            buf_data_q  <= buf_data_d;
            buf_last_q  <= buf_last_d;
        end
    end

    assign buf_valid_o = buf_valid_q;
    assign buf_ch_o    = buf_ch_q;
    assign buf_data_o  = buf_data_q;
    assign buf_last_o  = buf_last_q;

endmodule

// File: rtl/demux_stream_router.sv
// rtl/demux_stream_router.sv - packet-locked 1:N stream demultiplexer with drop counter
module demux_stream_router
    import demux_pkg::*;
#(
    parameter int            N_CH     = 4,
    parameter int            DW       = 1,
    parameter logic [DW-1:0] IDLE_VAL = '1,
    localparam int           SW       = clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DW-1:0]         in_data,
    input  logic [SW-1:0]         in_sel,
    input  logic                  in_last,
    output logic [N_CH-1:0]       out_valid,
    input  logic [N_CH-1:0]       out_ready,
    output logic [N_CH*DW-1:0]    out_data,
    output logic [N_CH-1:0]       out_last,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam logic [SW:0] N_CH_W = N_CH[SW:0];

    logic [0:0]            state_q, state_d;
    logic [SW-1:0]         lock_ch_q, lock_ch_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic          sel_bad;
    logic          drop;
    logic [SW-1:0] route_ch;
    logic          accept;
    logic          buf_valid;
    logic [SW-1:0] buf_ch;
    logic [DW-1:0] buf_data;
    logic          buf_last;

    // in_sel only matters on the first beat; once locked it is ignored.
    assign sel_bad  = ({1'b0, in_sel} >= N_CH_W);
    assign drop     = (state_q == ST_IDLE) && sel_bad;
    assign route_ch = (state_q == ST_LOCK) ? lock_ch_q : in_sel;

    demux_hold_reg #(
        .N_CH (N_CH),
        .DW   (DW),
        .SW   (SW)
    ) u_hold (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (en),
        .in_valid_i  (in_valid),
        .in_drop_i   (drop),
        .in_ch_i     (route_ch),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .out_ready_i (out_ready),
        .in_ready_o  (in_ready),
        .accept_o    (accept),
        .buf_valid_o (buf_valid),
        .buf_ch_o    (buf_ch),
        .buf_data_o  (buf_data),
        .buf_last_o  (buf_last)
    );

    always_comb begin
        state_d    = state_q;
        lock_ch_d  = lock_ch_q;
        drop_cnt_d = drop_cnt_q;
        if (accept) begin
            if (state_q == ST_IDLE) begin
                if (sel_bad) begin
                    if (drop_cnt_q != '1) begin
                        drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
                    end
                end else if (!in_last) begin
                    state_d   = ST_LOCK;
                    lock_ch_d = in_sel;
                end
            end else if (in_last) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            lock_ch_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_ch_q  <= lock_ch_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        out_valid = '0;
        out_last  = '0;
        out_data  = '0;
        for (int k = 0; k < N_CH; k++) begin
            out_valid[k]          = buf_valid && (buf_ch == k[SW-1:0]);
            out_last[k]           = buf_valid && (buf_ch == k[SW-1:0]) && buf_last;
            out_data[k*DW +: DW]  = (buf_valid && (buf_ch == k[SW-1:0])) ? buf_data : IDLE_VAL;
        end
    end

    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_demux_stream_router.sv
// tb/tb_demux_stream_router.sv - self-checking bench for demux_stream_router
module tb_demux_stream_router;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: N_CH=4, DW=8
    logic        a_rst_n, a_en, a_in_valid, a_in_ready, a_in_last;
    logic [7:0]  a_in_data;
    logic [1:0]  a_in_sel;
    logic [3:0]  a_out_valid, a_out_ready, a_out_last;
    logic [31:0] a_out_data;
    logic [7:0]  a_drop_cnt;

    // Instance B: N_CH=3, DW=8 (has unmapped select codes)
    logic        b_rst_n, b_en, b_in_valid, b_in_ready, b_in_last;
    logic [7:0]  b_in_data;
    logic [1:0]  b_in_sel;
    logic [2:0]  b_out_valid, b_out_ready, b_out_last;
    logic [23:0] b_out_data;
    logic [7:0]  b_drop_cnt;

    demux_stream_router #(.N_CH(4), .DW(8)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .en(a_en), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_sel(a_in_sel), .in_last(a_in_last), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .out_last(a_out_last), .drop_cnt(a_drop_cnt)
    );

    demux_stream_router #(.N_CH(3), .DW(8)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .en(b_en), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_sel(b_in_sel), .in_last(b_in_last), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last), .drop_cnt(b_drop_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [1:0] sel, input logic [7:0] d, input logic l);
        a_in_valid = v; a_in_sel = sel; a_in_data = d; a_in_last = l;
    endtask

    task automatic drive_b(input logic v, input logic [1:0] sel, input logic [7:0] d, input logic l);
        b_in_valid = v; b_in_sel = sel; b_in_data = d; b_in_last = l;
    endtask

    // Reference model for instance B: pending beat, packet lock, drop tally
    bit         m_pend, m_last, m_lock;
    int         m_ch, m_lch, m_drops;
    logic [7:0] m_data;

    task automatic model_reset();
        m_pend = 0; m_last = 0; m_lock = 0; m_ch = 0; m_lch = 0; m_drops = 0; m_data = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [23:0] e_data;
        logic [2:0]  e_valid, e_last;
        bit          e_ready, acc;
        int          ch;

        a_rst_n = 0; b_rst_n = 0;
        a_en = 1; b_en = 1;
        a_out_ready = 4'hF; b_out_ready = 3'h7;
        drive_a(1, 2, 8'h11, 0);
        drive_b(1, 3, 8'h00, 1);
        #12;
        check_eq("rst_a_ready", a_in_ready, 0);
        check_eq("rst_a_valid", a_out_valid, 0);
        check_eq("rst_a_last",  a_out_last, 0);
        check_eq("rst_a_data",  a_out_data, 32'hFFFF_FFFF);
        check_eq("rst_a_drop",  a_drop_cnt, 0);
        check_eq("rst_b_ready", b_in_ready, 0);
        check_eq("rst_b_data",  b_out_data, 24'hFF_FFFF);

        // 3-beat packet to channel 2, first acceptance on first edge after release
        a_rst_n = 1;
        b_en = 0; drive_b(0, 0, 0, 0); b_rst_n = 1;
        tick();
        check_eq("p35_v0", a_out_valid, 4'b0100);
        check_eq("p35_d0", a_out_data, 32'hFF11_FFFF);
        check_eq("p35_l0", a_out_last, 4'b0000);
        drive_a(1, 2, 8'h22, 0); tick();
        check_eq("p35_v1", a_out_valid, 4'b0100);
        check_eq("p35_d1", a_out_data, 32'hFF22_FFFF);
        drive_a(1, 2, 8'h33, 1); tick();
        check_eq("p35_v2", a_out_valid, 4'b0100);
        check_eq("p35_d2", a_out_data, 32'hFF33_FFFF);
        check_eq("p35_l2", a_out_last, 4'b0100);
        drive_a(0, 0, 8'h00, 0); tick();
        check_eq("p35_idle_v", a_out_valid, 4'b0000);
        check_eq("p35_idle_d", a_out_data, 32'hFFFF_FFFF);

        // select change mid-packet is ignored
        drive_a(1, 3, 8'hA1, 0); tick();
        check_eq("p36_v0", a_out_valid, 4'b1000);
        drive_a(1, 1, 8'hA2, 1); tick();
        check_eq("p36_v1", a_out_valid, 4'b1000);
        check_eq("p36_d1", a_out_data, 32'hA2FF_FFFF);
        check_eq("p36_l1", a_out_last, 4'b1000);
        drive_a(0, 0, 8'h00, 0); tick();

        // backpressure on channel 0
        a_out_ready = 4'b1110;
        drive_a(1, 0, 8'h55, 0); tick();
        check_eq("p38_v0", a_out_valid, 4'b0001);
        drive_a(1, 2, 8'h66, 1);
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("p38_stall_ready", a_in_ready, 0);
            check_eq("p38_stall_data", a_out_data, 32'hFFFF_FF55);
            check_eq("p38_stall_valid", a_out_valid, 4'b0001);
            tick();
        end
        a_out_ready = 4'hF;
        #1;
        check_eq("p38_release_ready", a_in_ready, 1);
        tick();
        check_eq("p38_next_v", a_out_valid, 4'b0001);
        check_eq("p38_next_d", a_out_data, 32'hFFFF_FF66);
        check_eq("p38_next_l", a_out_last, 4'b0001);
        drive_a(0, 0, 8'h00, 0); tick();

        // enable low mid-packet
        drive_a(1, 1, 8'h71, 0); tick();
        check_eq("p39_v0", a_out_valid, 4'b0010);
        a_en = 0;
        drive_a(1, 3, 8'h72, 1);
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("p39_en_ready", a_in_ready, 0);
            tick();
            check_eq("p39_drained", a_out_valid, 4'b0000);
        end
        a_en = 1;
        #1;
        check_eq("p39_resume_ready", a_in_ready, 1);
        tick();
        check_eq("p39_v1", a_out_valid, 4'b0010);
        check_eq("p39_d1", a_out_data, 32'hFFFF_72FF);
        drive_a(0, 0, 8'h00, 0); tick();

        // asynchronous reset during LOCK with a buffered beat
        drive_a(1, 2, 8'h81, 0); tick();
        check_eq("p40_v0", a_out_valid, 4'b0100);
        drive_a(0, 0, 8'h00, 0);
        #2 a_rst_n = 0;
        #1;
        check_eq("p40_rst_valid", a_out_valid, 4'b0000);
        check_eq("p40_rst_data", a_out_data, 32'hFFFF_FFFF);
        check_eq("p40_rst_last", a_out_last, 4'b0000);
        check_eq("p40_rst_ready", a_in_ready, 0);
        tick();
        a_rst_n = 1;
        drive_a(1, 0, 8'h91, 1); tick();
        check_eq("p40_after_v", a_out_valid, 4'b0001);
        check_eq("p40_after_d", a_out_data, 32'hFFFF_FF91);
        drive_a(0, 0, 8'h00, 0); tick();

        // drops on N_CH=3
        b_en = 1;
        for (int i = 0; i < 3; i++) begin
            drive_b(1, 3, 8'(8'hC0 + i), 1);
            #1;
            check_eq("p37_drop_ready", b_in_ready, 1);
            tick();
            check_eq("p37_drop_valid", b_out_valid, 3'b000);
        end
        check_eq("p37_drop3", b_drop_cnt, 3);
        drive_b(1, 3, 8'hEE, 0);
        repeat (260) tick();
        check_eq("p37_sat", b_drop_cnt, 255);
        check_eq("p37_sat_valid", b_out_valid, 3'b000);
        drive_b(0, 0, 8'h00, 0);

        // randomized traffic on N_CH=3 against the reference model
        b_rst_n = 0; tick(); b_rst_n = 1;
        model_reset();
        for (int cyc = 0; cyc < 500; cyc++) begin
            b_en        = ($urandom_range(0, 9) != 0);
            b_in_valid  = ($urandom_range(0, 9) < 7);
            b_in_sel    = 2'($urandom_range(0, 3));
            b_in_data   = 8'($urandom);
            b_in_last   = ($urandom_range(0, 2) == 0);
            b_out_ready = 3'($urandom);
            #1;
            e_ready = b_en && (!m_pend || b_out_ready[m_ch]);
            e_valid = m_pend ? 3'(1 << m_ch) : 3'b000;
            e_last  = (m_pend && m_last) ? 3'(1 << m_ch) : 3'b000;
            e_data  = 24'hFF_FFFF;
            if (m_pend) e_data[m_ch*8 +: 8] = m_data;
            check_eq("rnd_ready", b_in_ready, e_ready);
            check_eq("rnd_valid", b_out_valid, e_valid);
            check_eq("rnd_data",  b_out_data, e_data);
            check_eq("rnd_last",  b_out_last, e_last);
            check_eq("rnd_drop",  b_drop_cnt, m_drops);

            acc = b_in_valid && e_ready;
            if (m_pend && b_out_ready[m_ch]) m_pend = 0;
            if (acc) begin
                if (!m_lock && b_in_sel >= 3) begin
                    if (m_drops < 255) m_drops++;
                end else begin
                    ch = m_lock ? m_lch : int'(b_in_sel);
                    m_pend = 1; m_ch = ch; m_data = b_in_data; m_last = b_in_last;
                    if (!m_lock && !b_in_last) begin
                        m_lock = 1; m_lch = ch;
                    end else if (m_lock && b_in_last) begin
                        m_lock = 0;
                    end
                end
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_stream_router.md
DEMUX_STREAM_ROUTER -- requirements
Module: demux_stream_router

Interface
REQ-001 Parameter N_CH, default 4: number of output channels, legal range 2..16.
REQ-002 Parameter DW, default 1: data width per beat in bits.
REQ-003 Parameter IDLE_VAL, default all ones (DW bits): value driven on unselected or idle channel data.
REQ-004 Localparam SW = clog2(N_CH): select width.
REQ-005 clk  in  1  sole clock; all state changes on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert and active-low.
REQ-007 en  in  1  active-high enable; low blocks acceptance of new beats.
REQ-008 in_valid  in  1  input beat valid.
REQ-009 in_ready  out  1  input beat accepted when in_valid and in_ready are both high.
REQ-010 in_data  in  DW  input beat data.
REQ-011 in_sel  in  SW  destination channel, sampled on the first beat of a packet.
REQ-012 in_last  in  1  marks the final beat of a packet.
REQ-013 out_valid  out  N_CH  per-channel beat valid.
REQ-014 out_ready  in  N_CH  per-channel downstream ready.
REQ-015 out_data  out  N_CH*DW  channel k occupies bits [k*DW +: DW].
REQ-016 out_last  out  N_CH  per-channel last flag.
REQ-017 drop_cnt  out  8  count of discarded beats, saturating.

Function
REQ-018 Single holding register (buf_valid, buf_ch, buf_data, buf_last) SHALL sit between input and outputs: latency is exactly 1 cycle from acceptance to out_valid.
REQ-019 in_ready SHALL equal en && (!buf_valid || out_ready[buf_ch]), so back-to-back beats sustain one beat per cycle.
REQ-020 out_valid[buf_ch] SHALL equal buf_valid; all other out_valid bits SHALL be 0.
REQ-021 out_data of the selected channel SHALL be buf_data while buf_valid; every other channel, and an idle selected channel, SHALL carry IDLE_VAL.
REQ-022 out_last[buf_ch] SHALL equal buf_valid && buf_last; other bits SHALL be 0.
REQ-023 FSM states: IDLE and LOCK. In IDLE, an accepted beat with in_sel < N_CH latches in_sel as the locked channel and moves to LOCK unless in_last=1.
REQ-024 In LOCK, in_sel SHALL be ignored and beats route to the locked channel; an accepted beat with in_last=1 returns the FSM to IDLE.
REQ-025 In IDLE, an accepted beat with in_sel >= N_CH SHALL be discarded (buffer not loaded, no lock) and drop_cnt SHALL increment, holding at 255.
REQ-026 Dropping SHALL not stall the input; in_ready follows REQ-019 unchanged.
REQ-027 en low SHALL NOT flush: a beat already buffered drains normally, the FSM state and locked channel are retained, and acceptance resumes when en returns high.
REQ-028 Simultaneous drain and accept in one cycle SHALL replace the buffer contents without a bubble.
REQ-029 A channel whose out_ready stays low SHALL hold its out_data and out_last stable until the handshake completes.

Reset
REQ-030 While rst_n is low: buf_valid=0, FSM=IDLE, locked channel=0, drop_cnt=0, in_ready=0, out_valid=0, out_last=0, and every out_data channel=IDLE_VAL.
REQ-031 Reset asserted mid-packet SHALL discard the buffered beat and the lock without emitting a partial out_valid.
REQ-032 First acceptance after reset SHALL be possible in the first clock edge after rst_n deasserts.

Structure
REQ-033 Shared package demux_pkg SHALL hold the FSM state encoding (IDLE=0, LOCK=1), the clog2 function and the drop_cnt width constant (8).
REQ-034 One sub-module, demux_hold_reg, SHALL implement the holding register and handshake (REQ-018/019/028); channel decode, FSM and drop counter SHALL remain in the top level.

Verification
REQ-035 N_CH=4, DW=8: send 3-beat packet sel=2, data 0x11/0x22/0x33, out_ready=all 1 -> out_valid[2] high for 3 consecutive cycles, starting 1 cycle after the first acceptance, carrying 0x11, 0x22, 0x33; out_last[2] high with 0x33; channels 0, 1 and 3 read 0xFF.
REQ-036 Change in_sel to 1 on beat 2 of a packet locked to channel 3 -> beat 2 still appears on channel 3.
REQ-037 N_CH=3: send single-beat in_sel=3 three times -> no out_valid, drop_cnt=3; then 260 drops -> drop_cnt=255.
REQ-038 Hold out_ready[0]=0 for 5 cycles with a beat buffered for channel 0 -> in_ready=0 and out_data[0] stable; on release, the beat completes and the next beat is accepted in the same cycle.
REQ-039 Pull en low mid-packet for 4 cycles -> the buffered beat drains, no new acceptance, LOCK retained; remaining beats route to the same channel after en returns high.
REQ-040 Assert rst_n low during LOCK with buf_valid=1 -> all outputs return to reset values immediately (asynchronously); after release, a new packet with sel=0 routes correctly.
